// File: rtl/avl_pkg.sv
// Shared types and constants for the Avalon-style SRAM responder.
package avl_pkg;

  localparam int AVL_DATA_W = 32;
  localparam int AVL_BE_W   = 4;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RD_BURST = 2'd1,
    WR_BURST = 2'd2
  } avl_slave_state_t;

endpackage

// File: rtl/avl_sram_slave_if.sv
// Avalon-MM request/response bundle between the core LSU (master) and the SRAM responder (slave).
interface avl_sram_slave_if
  import avl_pkg::*;
#(
  parameter int BURST_W = 8
) ();

  logic [31:0]             address;
  logic                    read;
  logic                    write;
  logic [AVL_BE_W-1:0]     byte_en;
  logic [AVL_DATA_W-1:0]   write_data;
  logic                    begin_burst_transfer;
  logic [BURST_W-1:0]      burst_count;
  logic                    request_ready;
  logic [AVL_DATA_W-1:0]   read_data;
  logic                    read_data_valid;

  modport master (
    output address, read, write, byte_en, write_data, begin_burst_transfer, burst_count,
    input  request_ready, read_data, read_data_valid
  );

  modport slave (
    input  address, read, write, byte_en, write_data, begin_burst_transfer, burst_count,
    output request_ready, read_data, read_data_valid
  );

endinterface

// File: rtl/sram_sp_be.sv
// Single-port synchronous RAM, 4 byte lanes, read-first; read register resets to zero, array does not.
module sram_sp_be
  import avl_pkg::*;
#(
  parameter int    DEPTH     = 1024,
  parameter string INIT_FILE = "",
  parameter int    AW        = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  re,
  input  logic                  we,
  input  logic [AVL_BE_W-1:0]   be,
  input  logic [AW-1:0]         addr,
  input  logic [AVL_DATA_W-1:0] wdata,
  output logic [AVL_DATA_W-1:0] rdata
);

  logic [AVL_DATA_W-1:0] mem_r [DEPTH];
  logic [AVL_DATA_W-1:0] rdata_r;

  // Byte-lane write port
  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < AVL_BE_W; i++) begin
        if (be[i]) begin
          mem_r[addr][8*i +: 8] <= wdata[8*i +: 8];
        end
      end
    end
  end

  // Read register; holds its value between reads, so it doubles as the held output data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_r <= 32'h0000_0000;
    end else if (re) begin
      rdata_r <= mem_r[addr];
    end
  end

  assign rdata = rdata_r;

endmodule

// File: rtl/avl_sram_slave.sv
// Avalon-MM SRAM responder: single/burst reads and writes, fixed read latency, no response backpressure.
module avl_sram_slave
  import avl_pkg::*;
#(
  parameter int    DEPTH        = 1024,
  parameter int    BURST_W      = 8,
  parameter int    READ_LATENCY = 1,
  parameter string INIT_FILE    = ""
) (
  input  logic             clk,
  input  logic             rest,
  avl_sram_slave_if.slave  s0
);

  localparam int                 AW       = $clog2(DEPTH);
  localparam logic [BURST_W-1:0] ONE_BEAT = BURST_W'(1'b1);
  localparam logic [AW-1:0]      ONE_WORD = AW'(1'b1);

  avl_slave_state_t      state_r,    state_nxt_s;
  logic [AW-1:0]         addr_cnt_r, addr_cnt_nxt_s;
  logic [BURST_W-1:0]    rem_r,      rem_nxt_s;
  logic [AW-1:0]         idx_s;
  logic [AW-1:0]         ram_addr_s;
  logic                  ram_re_s;
  logic                  ram_we_s;
  logic                  ready_s;
  logic                  burst_multi_s;
  logic [AVL_DATA_W-1:0] ram_rdata_s;
  logic                  valid1_r;

  assign idx_s = s0.address[AW+1:2];
  // burst_count of 0 or 1 both mean a single beat
  assign burst_multi_s = s0.begin_burst_transfer && (s0.burst_count > ONE_BEAT);

  // Next-state, counter and RAM-command decode
  always_comb begin
    state_nxt_s    = state_r;
    addr_cnt_nxt_s = addr_cnt_r;
    rem_nxt_s      = rem_r;
    ram_re_s       = 1'b0;
    ram_we_s       = 1'b0;
    ram_addr_s     = idx_s;
    ready_s        = 1'b0;
    case (state_r)
      IDLE: begin
        ready_s = 1'b1;
        if (s0.read) begin
          ram_re_s = 1'b1;
          if (burst_multi_s) begin
            addr_cnt_nxt_s = idx_s + ONE_WORD;
            rem_nxt_s      = s0.burst_count - ONE_BEAT;
            state_nxt_s    = RD_BURST;
          end else begin
            state_nxt_s = IDLE;
          end
        end else if (s0.write) begin
          ram_we_s = 1'b1;
          if (burst_multi_s) begin
            addr_cnt_nxt_s = idx_s + ONE_WORD;
            rem_nxt_s      = s0.burst_count - ONE_BEAT;
            state_nxt_s    = WR_BURST;
          end else begin
            state_nxt_s = IDLE;
          end
        end else begin
          state_nxt_s = IDLE;
        end
      end
      RD_BURST: begin
        ram_re_s       = 1'b1;
        ram_addr_s     = addr_cnt_r;
        addr_cnt_nxt_s = addr_cnt_r + ONE_WORD;
        rem_nxt_s      = rem_r - ONE_BEAT;
        if (rem_r == ONE_BEAT) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = RD_BURST;
        end
      end
      WR_BURST: begin
        ready_s    = s0.write;
        ram_addr_s = addr_cnt_r;
        if (s0.write) begin
          ram_we_s       = 1'b1;
          addr_cnt_nxt_s = addr_cnt_r + ONE_WORD;
          rem_nxt_s      = rem_r - ONE_BEAT;
          if (rem_r == ONE_BEAT) begin
            state_nxt_s = IDLE;
          end else begin
            state_nxt_s = WR_BURST;
          end
        end else begin
          state_nxt_s = WR_BURST;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // FSM and burst counters
  always_ff @(posedge clk or negedge rest) begin
    if (!rest) begin
      state_r    <= IDLE;
      addr_cnt_r <= {AW{1'b0}};
      rem_r      <= {BURST_W{1'b0}};
    end else begin
      state_r    <= state_nxt_s;
      addr_cnt_r <= addr_cnt_nxt_s;
      rem_r      <= rem_nxt_s;
    end
  end

  sram_sp_be #(
    .DEPTH     (DEPTH),
    .INIT_FILE (INIT_FILE)
  ) u_ram (
    .clk   (clk),
    .rst_n (rest),
    .re    (ram_re_s),
    .we    (ram_we_s),
    .be    (s0.byte_en),
    .addr  (ram_addr_s),
    .wdata (s0.write_data),
    .rdata (ram_rdata_s)
  );

  // First latency stage: beat issued this cycle is valid next cycle
  always_ff @(posedge clk or negedge rest) begin
    if (!rest) begin
      valid1_r <= 1'b0;
    end else begin
      valid1_r <= ram_re_s;
    end
  end

  generate
    if (READ_LATENCY == 2) begin : g_lat2
      logic                  valid2_r;
      logic [AVL_DATA_W-1:0] data2_r;

      // Optional output register stage
      always_ff @(posedge clk or negedge rest) begin
        if (!rest) begin
          valid2_r <= 1'b0;
          data2_r  <= 32'h0000_0000;
        end else begin
          valid2_r <= valid1_r;
          if (valid1_r) begin
            data2_r <= ram_rdata_s;
          end
        end
      end

      assign s0.read_data_valid = valid2_r;
      assign s0.read_data       = data2_r;
    end else begin : g_lat1
      assign s0.read_data_valid = valid1_r;
      assign s0.read_data       = ram_rdata_s;
    end
  endgenerate

  assign s0.request_ready = ready_s;

endmodule

// File: tb/tb_avl_sram_slave.sv
// Directed bench for avl_sram_slave (DEPTH=1024, READ_LATENCY=1) with hand-computed expectations.
module tb_avl_sram_slave;
  import avl_pkg::*;

  logic clk = 1'b0;
  logic rest;
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  avl_sram_slave_if #(.BURST_W(8)) bus ();

  avl_sram_slave #(
    .DEPTH        (1024),
    .BURST_W      (8),
    .READ_LATENCY (1),
    .INIT_FILE    ("")
  ) dut (
    .clk  (clk),
    .rest (rest),
    .s0   (bus.slave)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_bus();
    bus.address              = 32'h0;
    bus.read                 = 1'b0;
    bus.write                = 1'b0;
    bus.byte_en              = 4'h0;
    bus.write_data           = 32'h0;
    bus.begin_burst_transfer = 1'b0;
    bus.burst_count          = 8'd0;
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] be);
    bus.address    = addr;
    bus.write      = 1'b1;
    bus.write_data = data;
    bus.byte_en    = be;
    step();
    idle_bus();
  endtask

  task automatic rd_check(input string tag, input logic [31:0] addr, input logic [31:0] exp);
    bus.address = addr;
    bus.read    = 1'b1;
    #1 chk({tag, "_ready"}, {31'h0, bus.request_ready}, 32'h1);
    step();
    idle_bus();
    chk({tag, "_valid"}, {31'h0, bus.read_data_valid}, 32'h1);
    chk({tag, "_data"}, bus.read_data, exp);
  endtask

  initial begin
    logic seen;
    idle_bus();
    rest = 1'b0;
    #12;
    chk("rst_ready", {31'h0, bus.request_ready}, 32'h1);
    chk("rst_valid", {31'h0, bus.read_data_valid}, 32'h0);
    chk("rst_data", bus.read_data, 32'h0);
    step();
    rest = 1'b1;
    step();

    // Byte-enable merge
    wr(32'h10, 32'hAAAA_AAAA, 4'hF);
    wr(32'h10, 32'h1122_3344, 4'b0101);
    rd_check("be_merge", 32'h10, 32'hAA22_AA44);
    step();
    chk("hold_valid", {31'h0, bus.read_data_valid}, 32'h0);
    chk("hold_data", bus.read_data, 32'hAA22_AA44);

    // 4-beat read burst
    wr(32'h20, 32'd1, 4'hF);
    wr(32'h24, 32'd2, 4'hF);
    wr(32'h28, 32'd3, 4'hF);
    wr(32'h2C, 32'd4, 4'hF);
    wr(32'h100, 32'h0BAD_F00D, 4'hF);
    bus.address = 32'h20; bus.read = 1'b1; bus.begin_burst_transfer = 1'b1; bus.burst_count = 8'd4;
    #1 chk("rb_accept_ready", {31'h0, bus.request_ready}, 32'h1);
    step();
    idle_bus();
    for (int i = 1; i <= 4; i++) begin
      chk($sformatf("rb_ready_%0d", i), {31'h0, bus.request_ready}, (i == 4) ? 32'h1 : 32'h0);
      chk($sformatf("rb_valid_%0d", i), {31'h0, bus.read_data_valid}, 32'h1);
      chk($sformatf("rb_data_%0d", i), bus.read_data, i);
      step();
    end
    chk("rb_end_valid", {31'h0, bus.read_data_valid}, 32'h0);

    // 3-beat write burst wrapping past the top word, with a gap cycle
    bus.address = 32'hFF8; bus.write = 1'b1; bus.begin_burst_transfer = 1'b1; bus.burst_count = 8'd3;
    bus.write_data = 32'hB0; bus.byte_en = 4'hF;
    step();
    bus.write = 1'b0; bus.begin_burst_transfer = 1'b0; bus.burst_count = 8'd0; bus.address = 32'h100;
    #1 chk("wb_gap_ready", {31'h0, bus.request_ready}, 32'h0);
    step();
    bus.write = 1'b1; bus.write_data = 32'hB1;
    #1 chk("wb_beat_ready", {31'h0, bus.request_ready}, 32'h1);
    step();
    bus.write_data = 32'hB2;
    step();
    idle_bus();
    #1 chk("wb_done_ready", {31'h0, bus.request_ready}, 32'h1);
    bus.address = 32'hFF8; bus.read = 1'b1; bus.begin_burst_transfer = 1'b1; bus.burst_count = 8'd3;
    step();
    idle_bus();
    chk("wrap_rd_0", bus.read_data, 32'hB0);
    step();
    chk("wrap_rd_1", bus.read_data, 32'hB1);
    step();
    chk("wrap_rd_2", bus.read_data, 32'hB2);
    step();
    rd_check("alias_word0", 32'h1000, 32'hB2);
    rd_check("master_addr_ignored", 32'h100, 32'h0BAD_F00D);

    // Back-to-back single reads
    wr(32'h0, 32'hC0, 4'hF);
    wr(32'h4, 32'hC1, 4'hF);
    wr(32'h8, 32'hC2, 4'hF);
    bus.read = 1'b1; bus.address = 32'h0;
    #1 chk("b2b_ready_0", {31'h0, bus.request_ready}, 32'h1);
    step();
    bus.address = 32'h4;
    #1 chk("b2b_ready_1", {31'h0, bus.request_ready}, 32'h1);
    chk("b2b_data_0", bus.read_data, 32'hC0);
    step();
    bus.address = 32'h8;
    #1 chk("b2b_ready_2", {31'h0, bus.request_ready}, 32'h1);
    chk("b2b_valid_1", {31'h0, bus.read_data_valid}, 32'h1);
    chk("b2b_data_1", bus.read_data, 32'hC1);
    step();
    idle_bus();
    chk("b2b_valid_2", {31'h0, bus.read_data_valid}, 32'h1);
    chk("b2b_data_2", bus.read_data, 32'hC2);
    step();
    chk("b2b_end_valid", {31'h0, bus.read_data_valid}, 32'h0);

    // Read wins over write; burst_count 0 is one beat
    wr(32'h40, 32'h5, 4'hF);
    bus.address = 32'h40; bus.read = 1'b1; bus.write = 1'b1;
    bus.write_data = 32'hDEAD_BEEF; bus.byte_en = 4'hF;
    step();
    idle_bus();
    chk("rw_data", bus.read_data, 32'h5);
    rd_check("rw_mem_unchanged", 32'h40, 32'h5);
    bus.address = 32'h40; bus.read = 1'b1; bus.write = 1'b1; bus.write_data = 32'hDEAD_BEEF;
    bus.byte_en = 4'hF; bus.begin_burst_transfer = 1'b1; bus.burst_count = 8'd0;
    step();
    idle_bus();
    chk("bc0_valid", {31'h0, bus.read_data_valid}, 32'h1);
    chk("bc0_data", bus.read_data, 32'h5);
    #1 chk("bc0_ready", {31'h0, bus.request_ready}, 32'h1);
    step();
    chk("bc0_single", {31'h0, bus.read_data_valid}, 32'h0);

    // Reset during beat 2 of an 8-beat read burst
    bus.address = 32'h80; bus.write = 1'b1; bus.begin_burst_transfer = 1'b1; bus.burst_count = 8'd8;
    bus.write_data = 32'hD0; bus.byte_en = 4'hF;
    step();
    bus.begin_burst_transfer = 1'b0; bus.burst_count = 8'd0;
    for (int i = 1; i < 8; i++) begin
      bus.write_data = 32'hD0 + i;
      step();
    end
    idle_bus();
    bus.address = 32'h80; bus.read = 1'b1; bus.begin_burst_transfer = 1'b1; bus.burst_count = 8'd8;
    step();
    idle_bus();
    chk("rst_burst_b0", bus.read_data, 32'hD0);
    step();
    chk("rst_burst_b1", bus.read_data, 32'hD1);
    #2 rest = 1'b0;
    #1 chk("rst_mid_valid", {31'h0, bus.read_data_valid}, 32'h0);
    chk("rst_mid_ready", {31'h0, bus.request_ready}, 32'h1);
    step();
    chk("rst_edge_valid", {31'h0, bus.read_data_valid}, 32'h0);
    rest = 1'b1;
    #1 chk("rst_release_ready", {31'h0, bus.request_ready}, 32'h1);
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      step();
      seen = seen | bus.read_data_valid;
    end
    chk("rst_no_more_beats", {31'h0, seen}, 32'h0);
    rd_check("rst_ram_intact_1", 32'h84, 32'hD1);
    rd_check("rst_ram_intact_7", 32'h9C, 32'hD7);
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
